// File: rtl/dmem_responder.sv
// Memory-side responder for MEM-stage data accesses.
// Accepts one load/store at a time, models a word-addressed RAM with a fixed
// number of wait states, and returns registered read data plus an address-error
// flag. Stall is held towards the pipeline while an access is pending.
//
// Handshake: a request is accepted on the rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE. resp_valid is a
// one-cycle pulse with resp_rdata/resp_err valid alongside it, and it has no
// back-pressure. The requester holds its inputs stable until resp_valid.
module dmem_responder #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam bit       ZERO_WAIT = (WAIT_CYC == 0);
    // The counter is loaded with WAIT_CYC-1 so that it sits in WAIT for WAIT_CYC cycles.
    localparam logic [3:0] WAIT_LOAD = 4'(ZERO_WAIT ? 0 : WAIT_CYC - 1);
    localparam int       DEPTH     = 1 << ADDR_W;

    state_t             state;
    logic [3:0]         wait_cnt;
    logic               lat_we;
    logic [31:0]        lat_addr;
    logic [31:0]        lat_wdata;
    logic [31:0]        mem [0:DEPTH-1];

    logic               enter_resp;
    logic               cur_we;
    logic [31:0]        cur_addr;
    logic [31:0]        cur_wdata;
    logic               addr_err;
    logic [ADDR_W-1:0]  word_idx;
    logic               mem_wr;

    // Select the request being completed. With zero wait states the RESP edge
    // is the accept edge, so the live inputs are used instead of the latched copy.
    always_comb begin
        enter_resp = 1'b0;
        cur_we     = lat_we;
        cur_addr   = lat_addr;
        cur_wdata  = lat_wdata;
        if (state == S_IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            enter_resp = req_valid & ZERO_WAIT;
        end else if (state == S_WAIT) begin
            enter_resp = (wait_cnt == 4'd0);
        end
        addr_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:ADDR_W+2] != '0);
        word_idx = cur_addr[ADDR_W+1:2];
        mem_wr   = enter_resp & cur_we & ~addr_err & ~rst;
    end

    // Stall must react in the same cycle the request appears, so it is combinational.
    assign stall     = ((state == S_IDLE) & req_valid) | (state == S_WAIT);
    assign req_ready = (state == S_IDLE);
    assign dbg_state = state;

    // Control FSM: accept, count wait states, produce the one-cycle response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        wait_cnt  <= WAIT_LOAD;
                        state     <= ZERO_WAIT ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            if (enter_resp) begin
                resp_valid <= 1'b1;
                resp_err   <= addr_err;
                resp_rdata <= (!cur_we && !addr_err) ? mem[word_idx] : 32'd0;
            end
        end
    end

    // Data RAM: store commits only on the edge entering RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[word_idx] <= cur_wdata;
        end
    end

endmodule
